// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// The state encoding lives here so the sequencer and any observers agree on it.
package multdiv_pkg;

  localparam int MD_CYCLES = 32;
  localparam int MD_ITER_W = 6;

  typedef enum logic [2:0] {
    MD_IDLE = 3'd0,
    MD_LOAD = 3'd1,
    MD_RUN  = 3'd2,
    MD_DONE = 3'd3,
    MD_EXC  = 3'd4
  } md_state_t;

  // A divide with a zero divisor never reaches the datapath.
  function automatic logic is_div_by_zero(input logic is_div, input logic divisor_zero);
    return is_div & divisor_zero;
  endfunction

endpackage

// File: rtl/multdiv_sequencer_iter_counter.sv
// Iteration index counter for the multiply/divide sequencer.
// Clear has priority over enable; the terminal flag is a plain compare on the count.
module iter_counter
  import multdiv_pkg::*;
#(
  parameter int unsigned TERMINAL = MD_CYCLES
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  output logic [MD_ITER_W-1:0] count,
  output logic                 terminal
);

  localparam logic [MD_ITER_W-1:0] TC = MD_ITER_W'(TERMINAL);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == TC);

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequencer in front of the iterative multiply/divide datapaths: latches operands,
// strobes the datapath load, counts iterations and captures the result.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | waiting for ctrl_MULT/ctrl_DIV; not busy
//   LOAD    | counter_zero high, datapath loads its initial state
//   RUN     | iter_count 1..CYCLES, datapath iterating
//   DONE    | datapath result valid; captured on the exit edge
//   EXC     | divide by zero; result forced to 0 with exception
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CYCLES = MD_CYCLES
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ctrl_MULT,
  input  logic                 ctrl_DIV,
  input  logic [WIDTH-1:0]     data_operandA,
  input  logic [WIDTH-1:0]     data_operandB,
  input  logic [WIDTH-1:0]     unit_result,
  input  logic                 unit_ovf,
  output logic [WIDTH-1:0]     unit_operandA,
  output logic [WIDTH-1:0]     unit_operandB,
  output logic                 unit_is_div,
  output logic                 counter_zero,
  output logic [MD_ITER_W-1:0] iter_count,
  output logic [WIDTH-1:0]     data_result,
  output logic                 data_exception,
  output logic                 data_resultRDY,
  output logic                 busy
);

  md_state_t state;
  logic      start;
  logic      cnt_clear;
  logic      cnt_enable;
  logic      cnt_terminal;

  assign start = ctrl_DIV | ctrl_MULT;

  // Count from 1 on the LOAD exit edge, freeze at CYCLES, drop to 0 once DONE ends.
  assign cnt_enable = (state == MD_LOAD) || ((state == MD_RUN) && !cnt_terminal);
  assign cnt_clear  = (state == MD_IDLE) || (state == MD_DONE) || (state == MD_EXC);

  iter_counter #(
    .TERMINAL (CYCLES)
  ) u_iter_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .count    (iter_count),
    .terminal (cnt_terminal)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= MD_IDLE;
      unit_operandA  <= '0;
      unit_operandB  <= '0;
      unit_is_div    <= 1'b0;
      counter_zero   <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      unique case (state)
        MD_IDLE: begin
          if (start) begin
            unit_operandA <= data_operandA;
            unit_operandB <= data_operandB;
            unit_is_div   <= ctrl_DIV;
            busy          <= 1'b1;
            if (is_div_by_zero(ctrl_DIV, data_operandB == '0)) begin
              state <= MD_EXC;
            end else begin
              state        <= MD_LOAD;
              counter_zero <= 1'b1;
            end
          end
        end
        MD_LOAD: begin
          counter_zero <= 1'b0;
          state        <= MD_RUN;
        end
        MD_RUN: begin
          if (cnt_terminal) begin
            state <= MD_DONE;
          end
        end
        MD_DONE: begin
          data_result    <= unit_result;
          data_exception <= unit_is_div ? 1'b0 : unit_ovf;
          data_resultRDY <= 1'b1;
          busy           <= 1'b0;
          state          <= MD_IDLE;
        end
        MD_EXC: begin
          data_result    <= '0;
          data_exception <= 1'b1;
          data_resultRDY <= 1'b1;
          busy           <= 1'b0;
          state          <= MD_IDLE;
        end
        default: begin
          state        <= MD_IDLE;
          busy         <= 1'b0;
          counter_zero <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer with a behavioural multiply/divide datapath.
module tb_multdiv_sequencer;

  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] unit_result;
  logic        unit_ovf;
  logic [31:0] unit_operandA;
  logic [31:0] unit_operandB;
  logic        unit_is_div;
  logic        counter_zero;
  logic [5:0]  iter_count;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  multdiv_sequencer #(.WIDTH(32), .CYCLES(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .unit_result    (unit_result),
    .unit_ovf       (unit_ovf),
    .unit_operandA  (unit_operandA),
    .unit_operandB  (unit_operandB),
    .unit_is_div    (unit_is_div),
    .counter_zero   (counter_zero),
    .iter_count     (iter_count),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural datapath: signed multiply with overflow, unsigned divide.
  // Overflow is forced high for divides so the sequencer's masking is visible.
  logic [63:0] prod;
  always_comb begin
    prod = {{32{unit_operandA[31]}}, unit_operandA} * {{32{unit_operandB[31]}}, unit_operandB};
    if (unit_is_div) begin
      unit_result = (unit_operandB == 32'd0) ? 32'hFFFF_FFFF : unit_operandA / unit_operandB;
      unit_ovf    = 1'b1;
    end else begin
      unit_result = prod[31:0];
      unit_ovf    = !((prod[63:31] == {33{1'b0}}) || (prod[63:31] == {33{1'b1}}));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_result"}, 64'(data_result), 64'd0);
    chk({tag, "_exc"}, 64'(data_exception), 64'd0);
    chk({tag, "_rdy"}, 64'(data_resultRDY), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_cz"}, 64'(counter_zero), 64'd0);
    chk({tag, "_iter"}, 64'(iter_count), 64'd0);
    chk({tag, "_isdiv"}, 64'(unit_is_div), 64'd0);
    chk({tag, "_opa"}, 64'(unit_operandA), 64'd0);
    chk({tag, "_opb"}, 64'(unit_operandB), 64'd0);
  endtask

  // Called in the cycle after the start edge; edges counts from that start edge.
  task automatic run_to_ready(output int edges, output int busy_cyc, output int cz_cyc,
                              output int last_iter);
    edges = 0; busy_cyc = 0; cz_cyc = 0; last_iter = 0;
    while (!data_resultRDY && edges < 60) begin
      if (busy) busy_cyc++;
      if (counter_zero) cz_cyc++;
      last_iter = int'(iter_count);
      tick();
      edges++;
    end
  endtask

  task automatic start_op(input logic mult, input logic div, input logic [31:0] a,
                          input logic [31:0] b);
    ctrl_MULT = mult; ctrl_DIV = div; data_operandA = a; data_operandB = b;
    tick();
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
  endtask

  int edges, busy_cyc, cz_cyc, last_iter, pulses, first_rdy;

  initial begin
    reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = '0; data_operandB = '0;
    tick(); tick();
    reset = 1'b0;
    chk_cleared("reset");

    // Divide 100 / 7
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    chk("div_load_cz", 64'(counter_zero), 64'd1);
    chk("div_load_busy", 64'(busy), 64'd1);
    chk("div_load_iter", 64'(iter_count), 64'd0);
    chk("div_opa", 64'(unit_operandA), 64'd100);
    chk("div_opb", 64'(unit_operandB), 64'd7);
    chk("div_isdiv", 64'(unit_is_div), 64'd1);
    run_to_ready(edges, busy_cyc, cz_cyc, last_iter);
    chk("div_ready_edge", 64'(edges), 64'd34);
    chk("div_busy_cycles", 64'(busy_cyc), 64'd34);
    chk("div_cz_cycles", 64'(cz_cyc), 64'd1);
    chk("div_done_iter", 64'(last_iter), 64'd32);
    chk("div_result", 64'(data_result), 64'd14);
    chk("div_exc", 64'(data_exception), 64'd0);
    chk("div_busy_at_rdy", 64'(busy), 64'd0);
    tick();
    chk("div_rdy_pulse", 64'(data_resultRDY), 64'd0);
    chk("div_idle_iter", 64'(iter_count), 64'd0);
    chk("div_result_held", 64'(data_result), 64'd14);

    // Divide by zero
    start_op(1'b0, 1'b1, 32'd5, 32'd0);
    chk("dz_no_cz", 64'(counter_zero), 64'd0);
    run_to_ready(edges, busy_cyc, cz_cyc, last_iter);
    chk("dz_ready_edge", 64'(edges), 64'd1);
    chk("dz_busy_cycles", 64'(busy_cyc), 64'd1);
    chk("dz_cz_cycles", 64'(cz_cyc), 64'd0);
    chk("dz_result", 64'(data_result), 64'd0);
    chk("dz_exc", 64'(data_exception), 64'd1);
    tick();

    // Multiply overflow: 0x7FFFFFFF * 2
    start_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd2);
    chk("mov_isdiv", 64'(unit_is_div), 64'd0);
    run_to_ready(edges, busy_cyc, cz_cyc, last_iter);
    chk("mov_ready_edge", 64'(edges), 64'd34);
    chk("mov_result", 64'(data_result), 64'hFFFF_FFFE);
    chk("mov_exc", 64'(data_exception), 64'd1);
    tick();

    // Simultaneous MULT+DIV, then a DIV during RUN cycle 10 that must be ignored
    start_op(1'b1, 1'b1, 32'd50, 32'd5);
    chk("sim_isdiv", 64'(unit_is_div), 64'd1);
    edges = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      edges++;
    end
    chk("sim_iter10", 64'(iter_count), 64'd10);
    ctrl_DIV = 1'b1; data_operandA = 32'd9; data_operandB = 32'd3;
    pulses = 0; first_rdy = 0;
    while (edges < 60) begin
      tick();
      edges++;
      ctrl_DIV = 1'b0;
      if (data_resultRDY) begin
        pulses++;
        if (first_rdy == 0) first_rdy = edges;
      end
    end
    chk("sim_pulses", 64'(pulses), 64'd1);
    chk("sim_ready_edge", 64'(first_rdy), 64'd34);
    chk("sim_result", 64'(data_result), 64'd10);
    chk("sim_opa_kept", 64'(unit_operandA), 64'd50);

    // Back-to-back: second divide issued in the ready cycle
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    run_to_ready(edges, busy_cyc, cz_cyc, last_iter);
    chk("b2b_first_edge", 64'(edges), 64'd34);
    start_op(1'b0, 1'b1, 32'd81, 32'd9);
    chk("b2b_load_cz", 64'(counter_zero), 64'd1);
    chk("b2b_rdy_low", 64'(data_resultRDY), 64'd0);
    run_to_ready(edges, busy_cyc, cz_cyc, last_iter);
    chk("b2b_second_edge", 64'(edges), 64'd34);
    chk("b2b_result", 64'(data_result), 64'd9);
    tick();

    // Reset mid-operation at iter_count == 20
    start_op(1'b1, 1'b0, 32'd6, 32'd7);
    for (int i = 0; i < 20; i++) tick();
    chk("rst_iter20", 64'(iter_count), 64'd20);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_cleared("rst_mid");
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (data_resultRDY) pulses++;
    end
    chk("rst_no_ready", 64'(pulses), 64'd0);
    start_op(1'b1, 1'b0, 32'd6, 32'd7);
    run_to_ready(edges, busy_cyc, cz_cyc, last_iter);
    chk("post_rst_edge", 64'(edges), 64'd34);
    chk("post_rst_result", 64'(data_result), 64'd42);
    chk("post_rst_exc", 64'(data_exception), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multdiv_sequencer.md
# multdiv_sequencer

Control stage that sits directly upstream of the iterative multiply/divide datapaths in the execute stage. It accepts a single-cycle `ctrl_MULT`/`ctrl_DIV` request from the pipeline and latches the operands. It drives the datapath's load strobe (`counter_zero`) and iteration count, then captures the finished result. It returns the result to the pipeline with a one-cycle ready pulse, a sticky exception flag and a busy/stall signal.

## Interface
- `WIDTH`, 32: operand/result width.
- `CYCLES`, 32: iteration cycles the datapath needs after load (`WIDTH` for restoring divide and shift-add multiply).
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high. Returns the block to IDLE and clears all registers.
- `ctrl_MULT`  in  1: start-multiply request, sampled only in IDLE.
- `ctrl_DIV`  in  1: start-divide request, sampled only in IDLE. Wins if sampled together with `ctrl_MULT`.
- `data_operandA`, `data_operandB`  in  WIDTH: operands, sampled on the start edge.
- `unit_result`  in  WIDTH: datapath result, valid in DONE.
- `unit_ovf`  in  1: datapath overflow, valid in DONE; meaningful for multiply only.
- `unit_operandA`, `unit_operandB`  out  WIDTH: latched operands, held stable from LOAD through DONE.
- `unit_is_div`  out  1: latched op type; selects the datapath.
- `counter_zero`  out  1: high only during LOAD; the datapath loads its initial state on the edge ending LOAD.
- `iter_count`  out  6: iteration index. 0 in LOAD, 1..CYCLES in RUN, held at CYCLES in DONE, 0 otherwise.
- `data_result`  out  WIDTH: captured result, held until the next capture.
- `data_exception`  out  1: captured exception, held with `data_result`.
- `data_resultRDY`  out  1: one-cycle pulse when `data_result`/`data_exception` update.
- `busy`  out  1: high in LOAD, RUN, DONE, EXC; the pipeline stalls on it.

## Operation
- States: IDLE, LOAD, RUN, DONE, EXC. Encoding is in the package.
- **IDLE:** if `ctrl_DIV` or `ctrl_MULT` is high, latch the operands and op type.
  - Divide with `data_operandB == 0`: go to EXC.
  - Otherwise: go to LOAD.
  - Requests while not IDLE are ignored; there is no queuing.
- **LOAD:** one cycle. `counter_zero = 1`; `iter_count` resets to 0. Go to RUN.
- **RUN:** `iter_count` increments each edge starting from 1. On the edge where `iter_count == CYCLES`, go to DONE.
- **DONE:** one cycle. On its ending edge:
  - `data_result <= unit_result`.
  - `data_exception <= unit_is_div ? 0 : unit_ovf`.
  - `data_resultRDY <= 1`; go to IDLE.
- **EXC:** one cycle. On its ending edge: `data_result <= 0`, `data_exception <= 1`, `data_resultRDY <= 1`; go to IDLE.
- `data_resultRDY` is registered and is high exactly the cycle after a DONE/EXC exit edge.
  - A new request is accepted in that same cycle because the state is already IDLE.
- Sign handling stays in the datapath. This block passes operands through unmodified.
- **Reset values:**
  - Outputs: `data_result = 0`, `data_exception = 0`, `data_resultRDY = 0`, `busy = 0`, `counter_zero = 0`, `iter_count = 0`, `unit_is_div = 0`, unit operands 0.
  - State: IDLE.
- **Reset mid-operation:** abandon the operation and do not pulse ready. The previous `data_result` is also cleared to 0.

## Timing
- Start edge is E0; the state entered at E0 is LOAD.
- LOAD occupies E0–E1 and RUN occupies E1–E(CYCLES+1). DONE occupies the next cycle.
- `data_resultRDY` is high in the cycle after E(CYCLES+2): 34 edges after start for the default CYCLES = 32.
- Divide-by-zero: EXC is entered at E0, and ready is high in the cycle after E1.
- `busy` rises in the cycle after E0 and falls in the same cycle that ready rises.
- The datapath sees `counter_zero` for exactly one edge (E1), followed by exactly CYCLES iteration edges before DONE samples `unit_result`.

## Structure
- Package `multdiv_pkg`: the state enum (`MD_IDLE`, `MD_LOAD`, `MD_RUN`, `MD_DONE`, `MD_EXC`), default `CYCLES`, and the `iter_count` width constant (6).
- One sub-module, `iter_counter`: a 6-bit synchronous up-counter with clear and enable, reset to 0, which produces the `iter_count == CYCLES` terminal flag.
- FSM, operand latches and result capture live in `multdiv_sequencer`.

## Test plan
- **Divide:** DIV pulse, A = 100, B = 7. Expect `counter_zero` high for one cycle after E0 and `busy` for 34 cycles. Model returns 14; expect ready at edge 34, `data_result = 14`, `data_exception = 0`.
- **Divide by zero:** DIV, A = 5, B = 0. Expect ready in the cycle after E1, `data_result = 0`, `data_exception = 1`, and no `counter_zero` pulse.
- **Multiply overflow:** MULT, A = 0x7FFF_FFFF, B = 2, model `unit_ovf = 1`. Expect `data_exception = 1` at ready; `data_result` equals the model result.
- **Simultaneous request and busy:** `ctrl_MULT` and `ctrl_DIV` high together. Expect `unit_is_div = 1`. A second `ctrl_DIV` issued at RUN cycle 10 is ignored, so exactly one ready pulse occurs.
- **Back-to-back:** new DIV issued in the ready cycle. Expect it accepted, LOAD in the next cycle, and the second ready exactly 34 edges later.
- **Reset mid-operation:** `reset` asserted at RUN `iter_count = 20`. Expect IDLE next cycle, all outputs 0, and no ready pulse. A subsequent operation completes normally.
